neuron_mac_sequencer: RTL

NEURON_MAC_SEQUENCER -- requirements
Module: neuron_mac_sequencer

---
 rtl/neuron_mac_sequencer_pkg.sv | 20 ++
 rtl/neuron_mac_unit.sv | 48 ++++
 rtl/neuron_mac_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/neuron_mac_sequencer_pkg.sv
// Shared definitions for the neuron MAC sequencer.
// Holds the Q8.8 format constants, the accumulator/address widths, the
// positive saturation limit and the sequencer state encoding.
package neuron_mac_sequencer_pkg;

  localparam int unsigned FRAC_BITS = 8;   // Q8.8 fractional bits
  localparam int unsigned DATA_W    = 16;  // Q8.8 operand width
  localparam int unsigned PROD_W    = 32;  // Q16.16 product width
  localparam int unsigned ACC_W     = 40;  // accumulator width, no wrap for 255 products
  localparam int unsigned ADDR_W    = 8;   // memory index width

  localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_FINISH = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

endpackage

// File: rtl/neuron_mac_unit.sv
// Multiply-accumulate datapath for the neuron sequencer.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   clear          synchronous accumulator clear (priority over accumulate)
//   rd_issue       memory read strobe; operands arrive one cycle later
//   input_data     signed Q8.8 activation
//   weight_data    signed Q8.8 weight
//   acc            signed 40-bit Q16.16 running sum
module neuron_mac_unit
  import neuron_mac_sequencer_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    rd_issue,
  input  logic [DATA_W-1:0]       input_data,
  input  logic [DATA_W-1:0]       weight_data,
  output logic signed [ACC_W-1:0] acc
);

  logic                     rd_valid;
  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] b_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;

  always_comb begin
    a_ext    = {{(PROD_W-DATA_W){input_data[DATA_W-1]}}, input_data};
    b_ext    = {{(PROD_W-DATA_W){weight_data[DATA_W-1]}}, weight_data};
    prod     = a_ext * b_ext;
    prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  end

  // rd_valid marks the cycle in which the memory's operands are valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      acc      <= '0;
    end else begin
      rd_valid <= rd_issue;
      if (clear)
        acc <= '0;
      else if (rd_valid)
        acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/neuron_mac_sequencer.sv
// Neuron MAC sequencer: on a rising start edge, reads N input/weight pairs,
// accumulates their products, adds the bias, applies ReLU and saturation and
// presents a Q8.8 result with a done level.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   start          start level; only a 0->1 transition starts a run
//   num_inputs     input count N, sampled on the accepted start edge
//   bias           signed Q8.8 bias, sampled on the accepted start edge
//   mem_addr       input/weight memory index
//   mem_rd         read strobe; data valid exactly one cycle later
//   input_data     signed Q8.8 activation
//   weight_data    signed Q8.8 weight
//   result         Q8.8 output after ReLU/saturation, held until next run
//   busy           high from accepted start until done
//   done           high after a run completes, cleared on next accepted start
module neuron_mac_sequencer
  import neuron_mac_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_inputs,
  input  logic [DATA_W-1:0] bias,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] input_data,
  input  logic [DATA_W-1:0] weight_data,
  output logic [DATA_W-1:0] result,
  output logic              busy,
  output logic              done
);

  logic [2:0]              state;
  logic                    start_q;
  logic                    start_edge;
  logic                    accept;
  logic [ADDR_W-1:0]       index;
  logic [ADDR_W-1:0]       num_q;
  logic [DATA_W-1:0]       bias_q;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] scaled;
  logic [DATA_W-1:0]       relu_sat;

  assign start_edge = start & ~start_q;
  assign accept     = start_edge && ((state == S_IDLE) || (state == S_DONE));

  // Read strobe and address come straight from state/index registers, so
  // mem_addr naturally holds its last value once RUN ends.
  assign mem_rd   = (state == S_RUN);
  assign mem_addr = index;

  neuron_mac_unit u_mac (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (accept),
    .rd_issue    (mem_rd),
    .input_data  (input_data),
    .weight_data (weight_data),
    .acc         (acc)
  );

  // Bias is aligned to Q16.16 before the add; the Q8.8 result is then the
  // arithmetic right shift. Any set bit above bit 14 of a positive value
  // means it exceeds the Q8.8 maximum.
  always_comb begin
    bias_ext = {{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q};
    sum      = acc + (bias_ext <<< FRAC_BITS);
    scaled   = sum >>> FRAC_BITS;
    if (scaled[ACC_W-1])
      relu_sat = '0;
    else if (|scaled[ACC_W-2:DATA_W-1])
      relu_sat = SAT_MAX;
    else
      relu_sat = scaled[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      start_q <= 1'b0;
      index   <= '0;
      num_q   <= '0;
      bias_q  <= '0;
      result  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      start_q <= start;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            num_q  <= num_inputs;
            bias_q <= bias;
            index  <= '0;
            done   <= 1'b0;
            busy   <= 1'b1;
            state  <= (num_inputs != '0) ? S_RUN : S_FINISH;
          end
        end
        S_RUN: begin
          if (index == num_q - 8'd1)
            state <= S_DRAIN;
          else
            index <= index + 8'd1;
        end
        S_DRAIN: begin
          state <= S_FINISH;
        end
        S_FINISH: begin
          result <= relu_sat;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
